// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, widths, round functions and the SHA-224 initial value.
package sha256_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned ROUNDS  = 64;
   localparam int unsigned BLOCK_W = 512;
   localparam int unsigned STATE_W = 256;
   localparam int unsigned WIN_N   = 16;
   localparam int unsigned IDX_W   = 6;

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

   localparam logic [STATE_W-1:0] SHA224_IV =
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

   function automatic logic [WORD_W-1:0] big_sigma0(input logic [WORD_W-1:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [WORD_W-1:0] big_sigma1(input logic [WORD_W-1:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] e,
                                            input logic [WORD_W-1:0] f,
                                            input logic [WORD_W-1:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] a,
                                             input logic [WORD_W-1:0] b,
                                             input logic [WORD_W-1:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word rolling message schedule window; w_t is always the oldest word.
module sha256_msg_sched
   import sha256_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 shift,
   input  logic [BLOCK_W-1:0]   block,
   output logic [WORD_W-1:0]    w_t
);

   logic [WORD_W-1:0] win [WIN_N];
   logic [WORD_W-1:0] w_new_c;

   assign w_new_c = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
   assign w_t     = win[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIN_N; i++) win[i] <= '0;
      end else if (load) begin
         for (int i = 0; i < WIN_N; i++) win[i] <= block[BLOCK_W-1-WORD_W*i -: WORD_W];
      end else if (shift) begin
         for (int i = 0; i < WIN_N-1; i++) win[i] <= win[i+1];
         win[WIN_N-1] <= w_new_c;
      end
   end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression engine, one round per cycle, digest over valid/ready.
// Define SHA224_EN to add the is_224 port and SHA-224 initial value / truncation.
module sha256_compress
   import sha256_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 block_valid,
   output logic                 block_ready,
   input  logic [BLOCK_W-1:0]   block,
   input  logic                 first,
`ifdef SHA224_EN
   input  logic                 is_224,
`endif
   output logic [IDX_W-1:0]     round_idx,
   input  logic [WORD_W-1:0]    k_t,
   input  logic [STATE_W-1:0]   iv,
   output logic [STATE_W-1:0]   digest,
   output logic                 digest_valid,
   input  logic                 digest_ready
);

   state_t              state;
   logic [STATE_W-1:0]  h_q;
   logic [WORD_W-1:0]   wv [8];
   logic [WORD_W-1:0]   w_t;
   logic                accept_c;
   logic [STATE_W-1:0]  iv_sel_c;
   logic [STATE_W-1:0]  seed_c;
   logic [STATE_W-1:0]  h_sum_c;
   logic [WORD_W-1:0]   t1_c;
   logic [WORD_W-1:0]   t2_c;

   assign accept_c = block_valid && block_ready;

`ifdef SHA224_EN
   logic mode224;
   assign iv_sel_c = is_224 ? SHA224_IV : iv;
   assign digest   = {h_q[STATE_W-1:WORD_W], mode224 ? {WORD_W{1'b0}} : h_q[WORD_W-1:0]};

   // Mode is captured only when a new message starts, so chained blocks keep it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  mode224 <= 1'b0;
      else if (accept_c && first)  mode224 <= is_224;
   end
`else
   assign iv_sel_c = iv;
   assign digest   = h_q;
`endif

   assign seed_c = first ? iv_sel_c : h_q;

   assign t1_c = wv[7] + big_sigma1(wv[4]) + ch(wv[4], wv[5], wv[6]) + k_t + w_t;
   assign t2_c = big_sigma0(wv[0]) + maj(wv[0], wv[1], wv[2]);

   always_comb begin
      h_sum_c = '0;
      for (int i = 0; i < 8; i++)
         h_sum_c[STATE_W-1-WORD_W*i -: WORD_W] = h_q[STATE_W-1-WORD_W*i -: WORD_W] + wv[i];
   end

   sha256_msg_sched u_sched (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (accept_c),
      .shift (state == ROUND),
      .block (block),
      .w_t   (w_t)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         round_idx    <= '0;
         block_ready  <= 1'b0;
         digest_valid <= 1'b0;
         h_q          <= '0;
         for (int i = 0; i < 8; i++) wv[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               block_ready <= 1'b1;
               if (accept_c) begin
                  state       <= ROUND;
                  block_ready <= 1'b0;
                  round_idx   <= '0;
                  if (first) h_q <= iv_sel_c;
                  for (int i = 0; i < 8; i++) wv[i] <= seed_c[STATE_W-1-WORD_W*i -: WORD_W];
               end
            end
            ROUND: begin
               wv[7] <= wv[6];
               wv[6] <= wv[5];
               wv[5] <= wv[4];
               wv[4] <= wv[3] + t1_c;
               wv[3] <= wv[2];
               wv[2] <= wv[1];
               wv[1] <= wv[0];
               wv[0] <= t1_c + t2_c;
               if (round_idx == IDX_W'(ROUNDS-1)) begin
                  state     <= FINAL;
                  round_idx <= '0;
               end else begin
                  round_idx <= round_idx + IDX_W'(1);
               end
            end
            FINAL: begin
               h_q          <= h_sum_c;
               state        <= DONE;
               digest_valid <= 1'b1;
            end
            DONE: begin
               if (digest_ready) begin
                  state        <= IDLE;
                  digest_valid <= 1'b0;
                  block_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: behavioural SHA-256 model plus known vectors.
module tb_sha256_compress;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [255:0] IV256 =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] IV224 =
      256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_M1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
      32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_M2 = {480'h0, 32'h000001c0};

   localparam logic [255:0] DIG_ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DIG_EMPTY =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] DIG_2BLK =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [255:0] DIG_224 =
      256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         block_valid;
   logic         block_ready;
   logic [511:0] block;
   logic         first;
   logic         is_224_d;
   logic [5:0]   round_idx;
   logic [31:0]  k_t;
   logic [255:0] iv;
   logic [255:0] digest;
   logic         digest_valid;
   logic         digest_ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign k_t = KT[round_idx];
   assign iv  = IV256;

   sha256_compress dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .block_valid  (block_valid),
      .block_ready  (block_ready),
      .block        (block),
      .first        (first),
`ifdef SHA224_EN
      .is_224       (is_224_d),
`endif
      .round_idx    (round_idx),
      .k_t          (k_t),
      .iv           (iv),
      .digest       (digest),
      .digest_valid (digest_valid),
      .digest_ready (digest_ready)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] b);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2, s0, s1;
      logic [255:0] r;
      for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = s1 + w[i-7] + s0 + w[i-16];
      end
      for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
            + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
      return r;
   endfunction

   // Cycle-level expectation: phase 0 idle, 1 rounds, 2 final, 3 holding digest.
   int           m_phase;
   int           m_cnt;
   logic         m_ready;
   logic         m_dvalid;
   logic         m_224;
   logic [255:0] m_h;
   logic [255:0] m_res;
   logic [255:0] m_hin;
   logic         eff224;

`ifdef SHA224_EN
   assign eff224 = is_224_d;
`else
   assign eff224 = 1'b0;
`endif

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_cnt = 0; m_ready = 1'b0; m_dvalid = 1'b0;
         m_224 = 1'b0; m_h = '0; m_res = '0;
      end else begin
         case (m_phase)
            0: if (m_ready && block_valid) begin
                  m_hin = first ? (eff224 ? IV224 : IV256) : m_h;
                  if (first) begin m_h = m_hin; m_224 = eff224; end
                  m_res = compress(m_hin, block);
                  m_phase = 1; m_cnt = 0;
               end
            1: if (m_cnt == 63) begin m_phase = 2; m_cnt = 0; end else m_cnt++;
            2: begin m_h = m_res; m_phase = 3; m_dvalid = 1'b1; end
            default: if (digest_ready) begin m_phase = 0; m_dvalid = 1'b0; end
         endcase
         m_ready = (m_phase == 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("block_ready", 256'(block_ready), 256'(m_ready));
         check("digest_valid", 256'(digest_valid), 256'(m_dvalid));
         check("round_idx", 256'(round_idx), 256'(m_phase == 1 ? m_cnt : 0));
         check("digest", digest, m_224 ? {m_h[255:32], 32'h0} : m_h);
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [511:0] b, input logic f, input logic m, input int hold,
                       input logic bp_valid, output logic [255:0] dig);
      int n; int lat; logic rdy; logic [255:0] held;
      block = b; first = f; is_224_d = m; block_valid = 1'b1;
      n = 0; rdy = 1'b0;
      while (!rdy && n < 200) begin
         rdy = block_ready;
         @(posedge clk); #1; n++;
      end
      check("accept_timeout", 256'(rdy), 256'(1));
      block_valid = 1'b0;
      for (int j = 0; j < 16; j++) block[511-32*j -: 32] = $urandom();
      first = 1'($urandom_range(0, 1));
      lat = 0;
      while (!digest_valid && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      check("latency_edges", 256'(lat), 256'(65));
      held = digest;
      block_valid = bp_valid;
      repeat (hold) begin @(posedge clk); #1; end
      check("digest_held", digest, held);
      digest_ready = 1'b1;
      dig = digest;
      @(posedge clk); #1;
      digest_ready = 1'b0;
      block_valid  = 1'b0;
      check("ready_after_release", 256'(block_ready), 256'(1));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [255:0] dig;
      logic [511:0] rb;
      int n;
      rst_n = 1'b0; block_valid = 1'b0; block = '0; first = 1'b0;
      is_224_d = 1'b0; digest_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_block_ready", 256'(block_ready), 256'(0));
      check("rst_digest_valid", 256'(digest_valid), 256'(0));
      check("rst_round_idx", 256'(round_idx), 256'(0));
      check("rst_digest", digest, '0);
      rst_n = 1'b1;

      check("model_abc", compress(IV256, BLK_ABC), DIG_ABC);
      check("model_empty", compress(IV256, BLK_EMPTY), DIG_EMPTY);
      check("model_2blk", compress(compress(IV256, BLK_M1), BLK_M2), DIG_2BLK);

      send(BLK_ABC, 1'b1, 1'b0, 0, 1'b0, dig);
      check("dut_abc", dig, DIG_ABC);
      send(BLK_EMPTY, 1'b1, 1'b0, 2, 1'b0, dig);
      check("dut_empty", dig, DIG_EMPTY);
      send(BLK_M1, 1'b1, 1'b0, 1, 1'b0, dig);
      send(BLK_M2, 1'b0, 1'b0, 0, 1'b0, dig);
      check("dut_2blk", dig, DIG_2BLK);

      // Back-pressure with an upstream block pending the whole time.
      send(BLK_EMPTY, 1'b1, 1'b0, 20, 1'b1, dig);
      check("dut_backpressure", dig, DIG_EMPTY);

      // Abort mid-round.
      block = BLK_ABC; first = 1'b1; block_valid = 1'b1;
      n = 0;
      while (!block_ready && n < 200) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      block_valid = 1'b0;
      n = 0;
      while (round_idx != 6'd30 && n < 200) begin @(posedge clk); #1; n++; end
      check("reach_round30", 256'(round_idx), 256'(30));
      #2 rst_n = 1'b0;
      #1;
      check("abort_digest", digest, '0);
      check("abort_digest_valid", 256'(digest_valid), 256'(0));
      check("abort_block_ready", 256'(block_ready), 256'(0));
      check("abort_round_idx", 256'(round_idx), 256'(0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      send(BLK_ABC, 1'b1, 1'b0, 0, 1'b0, dig);
      check("dut_abc_after_abort", dig, DIG_ABC);

`ifdef SHA224_EN
      send(BLK_ABC, 1'b1, 1'b1, 0, 1'b0, dig);
      check("dut_abc_224", dig, DIG_224);
      for (int j = 0; j < 16; j++) rb[511-32*j -: 32] = $urandom();
      send(rb, 1'b0, 1'b0, 1, 1'b0, dig);
      check("dut_224_sticky_low", dig[31:0], 32'h0);
      send(BLK_ABC, 1'b1, 1'b0, 0, 1'b0, dig);
      check("dut_abc_back_256", dig, DIG_ABC);
`endif

      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 16; j++) rb[511-32*j -: 32] = $urandom();
         send(rb, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), dig);
      end

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
